// File: rtl/usb_arb_pkg.sv
// Shared types and helpers for the USB-slave address arbiter family.
package usb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first requester at or after ptr (round-robin),
// or lowest requester index when mode is set (fixed priority).
module rr_pick
  import usb_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic [CH_W-1:0]   winner,
  output logic              any
);

  logic [NUM_CH-1:0] rot;
  int unsigned       idx;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    rot    = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (mode) begin
        idx = k;
      end else begin
        idx = (32'(ptr) + k) % NUM_CH;
      end
      rot = req >> idx;
      if (!any && rot[0]) begin
        any    = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/usb_addr_arb_mux.sv
// Arbitrates NUM_CH address sources onto one registered address toward the
// UHCI register decoder, with a valid/ready handshake and a grant pulse back.
module usb_addr_arb_mux
  import usb_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PRIO_MODE = 0,
  localparam int unsigned CH_W     = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic                     busy_o
);

  state_e            state;
  logic [CH_W-1:0]   ptr;
  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   win;
  logic              any;
  logic              mode;
  logic              take;
  logic              release_hold;
  logic [ADDR_W-1:0] sel_addr;
  logic [CH_W-1:0]   ptr_nxt;
  logic [NUM_CH-1:0] gnt_nxt;

  // The channel granted this cycle is masked so one request is never granted twice.
  assign eff_req = req_i & ~gnt_o;
  assign mode    = (PRIO_MODE == PRIO_FIXED);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req    (eff_req),
    .ptr    (ptr),
    .mode   (mode),
    .winner (win),
    .any    (any)
  );

  assign sel_addr     = ADDR_W'(addr_i >> (32'(win) * ADDR_W));
  assign ptr_nxt      = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
  assign gnt_nxt      = NUM_CH'(1) << win;
  assign take         = any && ((state == IDLE) || ready_i);
  assign release_hold = (state == HOLD) && ready_i && !any;

  // Capture on an idle request or on acceptance with more work pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_o  <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      gnt_o   <= '0;
      ptr     <= '0;
    end else begin
      gnt_o <= '0;
      if (take) begin
        state   <= HOLD;
        addr_o  <= sel_addr;
        ch_o    <= win;
        valid_o <= 1'b1;
        busy_o  <= 1'b1;
        gnt_o   <= gnt_nxt;
        ptr     <= ptr_nxt;
      end else if (release_hold) begin
        state   <= IDLE;
        addr_o  <= '0;
        ch_o    <= '0;
        valid_o <= 1'b0;
        busy_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_addr_arb_mux.sv
// Bench for usb_addr_arb_mux: three configurations (4ch round-robin, 2ch fixed,
// 1ch) against a cycle-level reference model of the arbitration rules.
module tb_usb_addr_arb_mux;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]  in_req  [NI];
  logic [31:0] in_addr [NI][4];
  logic        in_rdy  [NI];

  logic [3:0]   req_rr;
  logic [127:0] addr_rr;
  logic [31:0]  addr_o_rr;
  logic [1:0]   ch_rr;
  logic         valid_rr, busy_rr;
  logic [3:0]   gnt_rr;

  logic [1:0]   req_fx;
  logic [63:0]  addr_fx;
  logic [31:0]  addr_o_fx;
  logic         ch_fx;
  logic         valid_fx, busy_fx;
  logic [1:0]   gnt_fx;

  logic         req_one;
  logic [31:0]  addr_one;
  logic [31:0]  addr_o_one;
  logic         ch_one;
  logic         valid_one, busy_one;
  logic         gnt_one;

  logic [31:0] o_addr  [NI];
  logic [3:0]  o_ch    [NI];
  logic [3:0]  o_gnt   [NI];
  logic        o_valid [NI];
  logic        o_busy  [NI];

  logic        m_valid [NI];
  logic [31:0] m_addr  [NI];
  int          m_ch    [NI];
  logic [3:0]  m_gnt   [NI];
  int          m_ptr   [NI];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign req_rr   = in_req[0];
  assign addr_rr  = {in_addr[0][3], in_addr[0][2], in_addr[0][1], in_addr[0][0]};
  assign req_fx   = in_req[1][1:0];
  assign addr_fx  = {in_addr[1][1], in_addr[1][0]};
  assign req_one  = in_req[2][0];
  assign addr_one = in_addr[2][0];

  usb_addr_arb_mux #(.NUM_CH(4), .ADDR_W(32), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .req_i(req_rr), .addr_i(addr_rr), .addr_o(addr_o_rr),
    .ch_o(ch_rr), .valid_o(valid_rr), .ready_i(in_rdy[0]), .gnt_o(gnt_rr), .busy_o(busy_rr)
  );

  usb_addr_arb_mux #(.NUM_CH(2), .ADDR_W(32), .PRIO_MODE(1)) u_fx (
    .clk(clk), .rst(rst), .req_i(req_fx), .addr_i(addr_fx), .addr_o(addr_o_fx),
    .ch_o(ch_fx), .valid_o(valid_fx), .ready_i(in_rdy[1]), .gnt_o(gnt_fx), .busy_o(busy_fx)
  );

  usb_addr_arb_mux #(.NUM_CH(1), .ADDR_W(32), .PRIO_MODE(0)) u_one (
    .clk(clk), .rst(rst), .req_i(req_one), .addr_i(addr_one), .addr_o(addr_o_one),
    .ch_o(ch_one), .valid_o(valid_one), .ready_i(in_rdy[2]), .gnt_o(gnt_one), .busy_o(busy_one)
  );

  assign o_addr[0] = addr_o_rr;   assign o_addr[1] = addr_o_fx;   assign o_addr[2] = addr_o_one;
  assign o_ch[0]   = 4'(ch_rr);   assign o_ch[1]   = 4'(ch_fx);   assign o_ch[2]   = 4'(ch_one);
  assign o_gnt[0]  = gnt_rr;      assign o_gnt[1]  = 4'(gnt_fx);  assign o_gnt[2]  = 4'(gnt_one);
  assign o_valid[0] = valid_rr;   assign o_valid[1] = valid_fx;   assign o_valid[2] = valid_one;
  assign o_busy[0]  = busy_rr;    assign o_busy[1]  = busy_fx;    assign o_busy[2]  = busy_one;

  function automatic int nch(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  function automatic bit fixed_prio(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_ch[i]    = 0;
      m_gnt[i]   = '0;
      m_ptr[i]   = 0;
    end
  endtask

  // One clock edge of the arbitration rules, applied to the pre-edge inputs.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int n;
      int w;
      logic [3:0] eff;
      n   = nch(i);
      eff = in_req[i] & ~m_gnt[i] & 4'((1 << n) - 1);
      w   = -1;
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = fixed_prio(i) ? k : (m_ptr[i] + k) % n;
        if (w < 0 && ((eff >> idx) & 4'd1) != 4'd0) w = idx;
      end
      if (w >= 0 && (!m_valid[i] || in_rdy[i])) begin
        m_valid[i] = 1'b1;
        m_addr[i]  = in_addr[i][w];
        m_ch[i]    = w;
        m_gnt[i]   = 4'(1) << w;
        m_ptr[i]   = (w + 1) % n;
      end else if (m_valid[i] && in_rdy[i]) begin
        m_valid[i] = 1'b0;
        m_addr[i]  = '0;
        m_ch[i]    = 0;
        m_gnt[i]   = '0;
      end else begin
        m_gnt[i] = '0;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s/u%0d/valid", ph, i), 64'(o_valid[i]), 64'(m_valid[i]));
      chk($sformatf("%s/u%0d/busy", ph, i), 64'(o_busy[i]), 64'(m_valid[i]));
      chk($sformatf("%s/u%0d/addr", ph, i), 64'(o_addr[i]), 64'(m_addr[i]));
      chk($sformatf("%s/u%0d/ch", ph, i), 64'(o_ch[i]), 64'(m_ch[i]));
      chk($sformatf("%s/u%0d/gnt", ph, i), 64'(o_gnt[i]), 64'(m_gnt[i]));
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_req[i] = '0;
      in_rdy[i] = 1'b1;
      for (int k = 0; k < 4; k++) in_addr[i][k] = 32'h100 * (i + 1) + 32'(k);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single request on the 2-channel instance, channel 1 only.
    in_req[1]     = 4'b0010;
    in_addr[1][1] = 32'h0000_0040;
    step("single_cap");
    chk("single/addr", 64'(addr_o_fx), 64'h40);
    chk("single/ch", 64'(ch_fx), 64'd1);
    chk("single/gnt", 64'(gnt_fx), 64'b10);
    in_req[1] = '0;
    step("single_rel");
    chk("single/idle_addr", 64'(addr_o_fx), 64'h0);
    chk("single/idle_valid", 64'(valid_fx), 64'h0);

    // Back-pressure on the round-robin instance.
    in_req[0]     = 4'b0001;
    in_addr[0][0] = 32'h10;
    in_rdy[0]     = 1'b0;
    step("bp_cap");
    chk("bp/first_gnt", 64'(gnt_rr), 64'b0001);
    in_req[0] = '0;
    for (int c = 0; c < 5; c++) begin
      step("bp_hold");
      chk("bp/addr_hold", 64'(addr_o_rr), 64'h10);
      chk("bp/valid_hold", 64'(valid_rr), 64'h1);
      chk("bp/gnt_low", 64'(gnt_rr), 64'h0);
    end

    // Asynchronous reset while HOLD is pending; the transaction is dropped.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst/valid", 64'(valid_rr), 64'h0);
    #1 rst = 1'b0;
    in_rdy[0] = 1'b1;
    step("post_rst");
    chk("post_rst/gnt", 64'(gnt_rr), 64'h0);

    // Round-robin fairness, requesters drop on grant and return next cycle.
    for (int k = 0; k < 4; k++) in_addr[0][k] = 32'hA000 + 32'(k);
    in_req[0] = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step("rr_fair");
      chk($sformatf("rr_fair/ch%0d", c), 64'(ch_rr), 64'(exp_order[c]));
      chk($sformatf("rr_fair/valid%0d", c), 64'(valid_rr), 64'h1);
      in_req[0] = 4'hF & ~m_gnt[0];
    end
    in_req[0] = '0;
    step("rr_drain");

    // Fixed priority with both channels asserted, then channel 0 drops.
    in_rdy[1] = 1'b1;
    in_req[1] = 4'b0011;
    for (int c = 0; c < 4; c++) step("fx_both");
    in_req[1] = 4'b0010;
    for (int c = 0; c < 3; c++) step("fx_ch1");
    in_req[1] = '0;
    step("fx_drain");

    // Same-channel mask: a held request is not re-granted during its grant cycle.
    in_req[0] = 4'b0001;
    step("mask_cap");
    chk("mask/first_gnt", 64'(gnt_rr), 64'b0001);
    step("mask_gap");
    chk("mask/no_regrant", 64'(gnt_rr), 64'h0);
    chk("mask/idle", 64'(valid_rr), 64'h0);
    in_req[0] = 4'b0011;
    for (int c = 0; c < 4; c++) step("mask_pair");
    in_req[0] = '0;
    step("mask_drain");

    // Randomized traffic on all three configurations.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        in_req[i] = 4'($urandom) & 4'((1 << nch(i)) - 1);
        in_rdy[i] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) in_addr[i][k] = $urandom;
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
